// File: rtl/otp_pkg.sv
// Shared definitions for the OTP command sequencer: controller mode codes, response status and FSM states.
// The optional read-back verify step is enabled with the OTP_SEQ_VERIFY_EN macro (see otp_cmd_sequencer).
package otp_pkg;

    localparam logic [1:0] MODE_READING = 2'b00;
    localparam logic [1:0] MODE_WRITING = 2'b01;
    localparam logic [1:0] MODE_IDLE    = 2'b10;

    typedef enum logic [1:0] {
        ST_OK          = 2'b00,
        ST_WRITE_FAIL  = 2'b01,
        ST_TIMEOUT     = 2'b10,
        ST_VERIFY_FAIL = 2'b11
    } status_t;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_PULSE = 3'd1,
        S_WR_GAP   = 3'd2,
        S_RD_WAIT  = 3'd3,
        S_VERIFY   = 3'd4,
        S_RESP     = 3'd5
    } state_t;

    // Controller mode presented while the sequencer sits in a given state
    function automatic logic [1:0] mode_for_state(input state_t s);
        logic [1:0] m;
        case (s)
            S_WR_PULSE: m = MODE_WRITING;
            S_RD_WAIT:  m = MODE_READING;
            S_VERIFY:   m = MODE_READING;
            default:    m = MODE_IDLE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/otp_cycle_timer.sv
// Saturating down-counter: reloaded by i_load, counts while i_en, o_expired when it reaches zero.
module otp_cycle_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_expired
);

    logic [W-1:0] r_count;

    // Count register: load has priority, decrement stops at zero
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= {W{1'b0}};
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != {W{1'b0}})) begin
            r_count <= r_count - W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_expired = (r_count == {W{1'b0}});

endmodule

// File: rtl/otp_cmd_sequencer.sv
// Host-facing command stage for the OTP array controller: read / program with retry, one response per request.
// Define OTP_SEQ_VERIFY_EN to read back and compare the word after every successful program.
import otp_pkg::*;

module otp_cmd_sequencer #(
    parameter int A            = 2,
    parameter int B            = 2,
    parameter int ADDR_WIDTH   = (B > 1) ? $clog2(B) : 1,
    parameter int PULSE_CYCLES = 4,
    parameter int MAX_RETRY    = 3,
    parameter int TIMEOUT      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_col,
    input  logic [A-1:0]          req_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [A-1:0]          rsp_data,
    output logic [1:0]            rsp_status,
    output logic [1:0]            mode,
    output logic [ADDR_WIDTH-1:0] column,
    output logic [A-1:0]          data_in,
    input  logic                  writing_successful,
    input  logic                  read_active,
    input  logic [A-1:0]          ctrl_data_out
);

    localparam int T_MAX = (PULSE_CYCLES > TIMEOUT) ? PULSE_CYCLES : TIMEOUT;
    localparam int TW    = $clog2(T_MAX + 1);
    localparam int AW    = $clog2(MAX_RETRY + 1);
    localparam logic [TW-1:0] PULSE_LOAD    = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LOAD  = TW'(TIMEOUT - 1);
    localparam logic [AW-1:0] ATTEMPT_LIMIT = AW'(MAX_RETRY);

    state_t                r_state,      w_state_nx;
    logic [1:0]            r_mode;
    logic [ADDR_WIDTH-1:0] r_col,        w_col_nx;
    logic [A-1:0]          r_data,       w_data_nx;
    logic [AW-1:0]         r_attempt,    w_attempt_nx;
    logic                  r_wr_ok,      w_wr_ok_nx;
    logic                  r_rsp_valid;
    logic                  r_req_ready;
    logic [A-1:0]          r_rsp_data,   w_rsp_data_nx;
    status_t               r_rsp_status, w_rsp_status_nx;
    logic                  w_tmr_load;
    logic [TW-1:0]         w_tmr_val;
    logic                  w_tmr_expired;

    // One timer serves both the program window and the read timeout; it reloads on each state entry
    otp_cycle_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_en       (1'b1),
        .o_expired  (w_tmr_expired)
    );

    // Next-state, request latching and response field selection
    always_comb begin
        w_state_nx      = r_state;
        w_col_nx        = r_col;
        w_data_nx       = r_data;
        w_attempt_nx    = r_attempt;
        w_wr_ok_nx      = r_wr_ok;
        w_rsp_data_nx   = r_rsp_data;
        w_rsp_status_nx = r_rsp_status;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_col_nx     = req_col;
                    w_data_nx    = req_data;
                    w_attempt_nx = {AW{1'b0}};
                    w_wr_ok_nx   = 1'b0;
                    w_state_nx   = req_write ? S_WR_PULSE : S_RD_WAIT;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_WR_PULSE: begin
                if (writing_successful) begin
                    w_wr_ok_nx = 1'b1;
                    w_state_nx = S_WR_GAP;
                end else if (w_tmr_expired) begin
                    w_attempt_nx = r_attempt + AW'(1);
                    w_state_nx   = S_WR_GAP;
                end else begin
                    w_state_nx = S_WR_PULSE;
                end
            end
            S_WR_GAP: begin
                if (r_wr_ok) begin
`ifdef OTP_SEQ_VERIFY_EN
                    w_state_nx = S_VERIFY;
`else
                    w_rsp_data_nx   = r_data;
                    w_rsp_status_nx = ST_OK;
                    w_state_nx      = S_RESP;
`endif
                end else if (r_attempt == ATTEMPT_LIMIT) begin
                    w_rsp_data_nx   = {A{1'b0}};
                    w_rsp_status_nx = ST_WRITE_FAIL;
                    w_state_nx      = S_RESP;
                end else begin
                    w_state_nx = S_WR_PULSE;
                end
            end
            S_RD_WAIT: begin
                if (read_active) begin
                    w_rsp_data_nx   = ctrl_data_out;
                    w_rsp_status_nx = ST_OK;
                    w_state_nx      = S_RESP;
                end else if (w_tmr_expired) begin
                    w_rsp_data_nx   = {A{1'b0}};
                    w_rsp_status_nx = ST_TIMEOUT;
                    w_state_nx      = S_RESP;
                end else begin
                    w_state_nx = S_RD_WAIT;
                end
            end
`ifdef OTP_SEQ_VERIFY_EN
            S_VERIFY: begin
                if (read_active) begin
                    w_rsp_data_nx   = ctrl_data_out;
                    w_rsp_status_nx = (ctrl_data_out == r_data) ? ST_OK : ST_VERIFY_FAIL;
                    w_state_nx      = S_RESP;
                end else if (w_tmr_expired) begin
                    w_rsp_data_nx   = {A{1'b0}};
                    w_rsp_status_nx = ST_TIMEOUT;
                    w_state_nx      = S_RESP;
                end else begin
                    w_state_nx = S_VERIFY;
                end
            end
`endif
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_state_nx = S_RESP;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        w_tmr_load = (w_state_nx != r_state);
        if (w_state_nx == S_WR_PULSE) begin
            w_tmr_val = PULSE_LOAD;
        end else begin
            w_tmr_val = TIMEOUT_LOAD;
        end
    end

    // State and registered outputs; outputs are decoded from the next state so they align with it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_mode       <= MODE_IDLE;
            r_col        <= {ADDR_WIDTH{1'b0}};
            r_data       <= {A{1'b0}};
            r_attempt    <= {AW{1'b0}};
            r_wr_ok      <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_req_ready  <= 1'b1;
            r_rsp_data   <= {A{1'b0}};
            r_rsp_status <= ST_OK;
        end else begin
            r_state      <= w_state_nx;
            r_mode       <= mode_for_state(w_state_nx);
            r_col        <= w_col_nx;
            r_data       <= w_data_nx;
            r_attempt    <= w_attempt_nx;
            r_wr_ok      <= w_wr_ok_nx;
            r_rsp_valid  <= (w_state_nx == S_RESP);
            r_req_ready  <= (w_state_nx == S_IDLE);
            r_rsp_data   <= w_rsp_data_nx;
            r_rsp_status <= w_rsp_status_nx;
        end
    end

    assign req_ready  = r_req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_status = r_rsp_status;
    assign mode       = r_mode;
    assign column     = r_col;
    assign data_in    = r_data;

endmodule
